// File: rtl/hvac_zone_arbiter.sv
// Round-robin compressor arbiter for NZONES cooling zones. Urgent requests win selection, and
// min/max run and rest times are enforced. Optional `URGENT_PREEMPT_EN lets urgent requests cut a run short.
module hvac_zone_arbiter #(
  parameter int unsigned NZONES = 4,
  parameter int unsigned MIN_ON = 8,
  parameter int unsigned MAX_ON = 32,
  parameter int unsigned REST   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [NZONES-1:0] req,
  input  logic [NZONES-1:0] urgent,
  output logic [NZONES-1:0] grant,
  output logic [2:0]        grant_id,
  output logic              compressor_on,
  output logic              lockout
);

  localparam int unsigned IdxW = (NZONES > 1) ? $clog2(NZONES) : 1;
  localparam logic [7:0]  MinOn   = 8'(MIN_ON);
  localparam logic [7:0]  MaxOn   = 8'(MAX_ON);
  localparam logic [7:0]  RestCnt = 8'(REST);

  if (NZONES < 2 || NZONES > 8) begin : gen_bad_nzones
    $error("NZONES must be in 2..8");
  end
  if (MIN_ON < 1 || MIN_ON > 255 || MAX_ON < MIN_ON || MAX_ON > 255 || REST > 255) begin : gen_bad_t
    $error("timing parameters out of range");
  end

  typedef enum logic [1:0] {StIdle, StRun, StRest} state_e;

  state_e              state_q, state_d;
  logic [7:0]          on_cnt_q, on_cnt_d;
  logic [7:0]          rest_cnt_q, rest_cnt_d;
  logic [IdxW-1:0]     last_id_q, last_id_d;
  logic [NZONES-1:0]   grant_q, grant_d;
  logic [2:0]          grant_id_q, grant_id_d;
  logic                comp_q, comp_d;
  logic                lockout_q, lockout_d;

  // Round-robin winner search starting just after the last served zone.
  logic [NZONES-1:0]   cand;
  logic                win_found;
  logic [IdxW-1:0]     win_idx;

  always_comb begin
    int idx_i;
    cand      = ((req & urgent) != '0) ? (req & urgent) : req;
    win_found = 1'b0;
    win_idx   = '0;
    idx_i     = 0;
    for (int i = 1; i <= int'(NZONES); i++) begin
      idx_i = (int'(last_id_q) + i) % int'(NZONES);
      if (!win_found && cand[idx_i[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx_i[IdxW-1:0];
      end
    end
  end

  // Release qualifiers are taken from the counter value after this cycle's tick.
  logic [7:0] on_nxt;
  logic [7:0] rest_nxt;
  logic       own_req;
  logic       other_req;
  logic       own_urg;
  logic       other_urg;
  logic       min_ok;
  logic       max_hit;
  logic       preempt;
  logic       release_run;

  always_comb begin
    on_nxt    = (tick && on_cnt_q != 8'hFF) ? on_cnt_q + 8'd1 : on_cnt_q;
    rest_nxt  = (tick && rest_cnt_q != 8'hFF) ? rest_cnt_q + 8'd1 : rest_cnt_q;
    own_req   = |(req & grant_q);
    other_req = |(req & ~grant_q);
    own_urg   = |(req & urgent & grant_q);
    other_urg = |(req & urgent & ~grant_q);
    min_ok    = (on_nxt >= MinOn);
    max_hit   = (on_nxt >= MaxOn);
`ifdef URGENT_PREEMPT_EN
    preempt   = min_ok && !own_urg && other_urg;
`else
    preempt   = 1'b0;
`endif
    release_run = (min_ok && !own_req) || (max_hit && other_req) || preempt;
  end

  always_comb begin
    state_d    = state_q;
    on_cnt_d   = on_cnt_q;
    rest_cnt_d = rest_cnt_q;
    last_id_d  = last_id_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    comp_d     = comp_q;
    lockout_d  = lockout_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d           = StRun;
          on_cnt_d          = 8'd0;
          last_id_d         = win_idx;
          grant_d           = '0;
          grant_d[win_idx]  = 1'b1;
          grant_id_d        = 3'(win_idx);
          comp_d            = 1'b1;
        end
      end
      StRun: begin
        on_cnt_d = on_nxt;
        if (release_run) begin
          grant_d    = '0;
          grant_id_d = 3'd0;
          comp_d     = 1'b0;
          rest_cnt_d = 8'd0;
          if (REST == 0) begin
            state_d   = StIdle;
            lockout_d = 1'b0;
          end else begin
            state_d   = StRest;
            lockout_d = 1'b1;
          end
        end
      end
      StRest: begin
        rest_cnt_d = rest_nxt;
        if (rest_nxt >= RestCnt) begin
          state_d   = StIdle;
          lockout_d = 1'b0;
        end
      end
      default: begin
        state_d    = StIdle;
        grant_d    = '0;
        grant_id_d = 3'd0;
        comp_d     = 1'b0;
        lockout_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      on_cnt_q   <= 8'd0;
      rest_cnt_q <= 8'd0;
      last_id_q  <= IdxW'(NZONES - 1);
      grant_q    <= '0;
      grant_id_q <= 3'd0;
      comp_q     <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      on_cnt_q   <= on_cnt_d;
      rest_cnt_q <= rest_cnt_d;
      last_id_q  <= last_id_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      comp_q     <= comp_d;
      lockout_q  <= lockout_d;
    end
  end

  assign grant         = grant_q;
  assign grant_id      = grant_id_q;
  assign compressor_on = comp_q;
  assign lockout       = lockout_q;

endmodule

// File: tb/tb_hvac_zone_arbiter.sv
// Scoreboard bench for hvac_zone_arbiter with NZONES=4, MIN_ON=3, MAX_ON=6, REST=2.
// Expected cycle timelines are queued as stimulus is driven, then popped against sampled outputs.
module tb_hvac_zone_arbiter;

  typedef struct packed {
    logic       lock;
    logic       comp;
    logic [2:0] id;
    logic [3:0] g;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [3:0] req;
  logic [3:0] urgent;
  logic [3:0] grant;
  logic [2:0] grant_id;
  logic       compressor_on;
  logic       lockout;
  exp_t       obs;

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;

  hvac_zone_arbiter #(
    .NZONES(4),
    .MIN_ON(3),
    .MAX_ON(6),
    .REST  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .req          (req),
    .urgent       (urgent),
    .grant        (grant),
    .grant_id     (grant_id),
    .compressor_on(compressor_on),
    .lockout      (lockout)
  );

  assign obs = {lockout, compressor_on, grant_id, grant};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] g, input logic [2:0] id, input logic lock);
    exp_t e;
    e.lock = lock;
    e.comp = (g != 4'b0000);
    e.id   = id;
    e.g    = g;
    return e;
  endfunction

  // Apply inputs for one cycle; returns 1 time unit after the edge.
  task automatic drive(input logic [3:0] r, input logic [3:0] u, input logic t);
    req    = r;
    urgent = u;
    tick   = t;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    req = 4'b0000; urgent = 4'b0000; tick = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk(4'b0000, 3'd0, 1'b0));
    e = exp_q.pop_front();
    n_total++;
    if (obs !== e) $display("FAIL reset_state: got %b want %b", obs, e);
    else n_pass++;
    reset = 1'b0;
  endtask

  // Zone 0 alone, request dropped after one tick: held until MIN_ON, then REST.
  task automatic test_basic();
    logic [3:0] rq [7] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    exp_t ex [7];
    exp_t e;
    ex = '{mk(4'b0001, 3'd0, 1'b0), mk(4'b0001, 3'd0, 1'b0), mk(4'b0001, 3'd0, 1'b0),
           mk(4'b0000, 3'd0, 1'b1), mk(4'b0000, 3'd0, 1'b1), mk(4'b0000, 3'd0, 1'b0),
           mk(4'b0000, 3'd0, 1'b0)};
    for (int k = 0; k < 7; k++) begin
      exp_q.push_back(ex[k]);
      drive(rq[k], 4'b0000, 1'b1);
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL basic cyc%0d: got %b want %b", k, obs, e);
      else n_pass++;
    end
  endtask

  // Last served zone 0; urgent zone 2 must beat round-robin choice zone 1.
  task automatic test_urgent_select();
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      if (k < 3)      exp_q.push_back(mk(4'b0100, 3'd2, 1'b0));
      else if (k < 5) exp_q.push_back(mk(4'b0000, 3'd0, 1'b1));
      else            exp_q.push_back(mk(4'b0000, 3'd0, 1'b0));
      if (k == 0) drive(4'b0110, 4'b0100, 1'b1);
      else        drive(4'b0000, 4'b0000, 1'b1);
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL urgent_select cyc%0d: got %b want %b", k, obs, e);
      else n_pass++;
    end
  endtask

  // All zones requesting from a fresh reset: 0,1,2,3,0 each for MAX_ON, REST between.
  task automatic test_rotation();
    exp_t e;
    logic [3:0] gz;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    for (int it = 0; it < 5; it++) begin
      gz = 4'b0001 << (it % 4);
      for (int j = 0; j < 9; j++) begin
        if (j < 6)      exp_q.push_back(mk(gz, 3'(it % 4), 1'b0));
        else if (j < 8) exp_q.push_back(mk(4'b0000, 3'd0, 1'b1));
        else            exp_q.push_back(mk(4'b0000, 3'd0, 1'b0));
        drive(4'b1111, 4'b0000, 1'b1);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL rotation z%0d cyc%0d: got %b want %b", it % 4, j, obs, e);
        else n_pass++;
      end
    end
    exp_q.push_back(mk(4'b0000, 3'd0, 1'b0));
    drive(4'b0000, 4'b0000, 1'b1);
    e = exp_q.pop_front();
    n_total++;
    if (obs !== e) $display("FAIL rotation drain: got %b want %b", obs, e);
    else n_pass++;
  endtask

  // Zone 1 running, zone 3 raises req+urgent once zone 1 reaches on_cnt=4.
  task automatic test_urgent_run();
    exp_t e;
    int   d;
    int   rel;
    int   g3;
`ifdef URGENT_PREEMPT_EN
    d = 0;
`else
    d = 1;
`endif
    rel = 5 + d;
    g3  = rel + 3;
    for (int k = 0; k <= g3 + 5; k++) begin
      if (k < rel)                       exp_q.push_back(mk(4'b0010, 3'd1, 1'b0));
      else if (k < rel + 2)              exp_q.push_back(mk(4'b0000, 3'd0, 1'b1));
      else if (k == rel + 2)             exp_q.push_back(mk(4'b0000, 3'd0, 1'b0));
      else if (k < g3 + 3)               exp_q.push_back(mk(4'b1000, 3'd3, 1'b0));
      else if (k < g3 + 5)               exp_q.push_back(mk(4'b0000, 3'd0, 1'b1));
      else                               exp_q.push_back(mk(4'b0000, 3'd0, 1'b0));
      if (k < 5)        drive(4'b0010, 4'b0000, 1'b1);
      else if (k <= g3) drive(4'b1010, 4'b1000, 1'b1);
      else              drive(4'b0000, 4'b0000, 1'b1);
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL urgent_run cyc%0d: got %b want %b", k, obs, e);
      else n_pass++;
    end
  endtask

  // tick low freezes on_cnt, so a dropped request keeps the grant until ticks return.
  task automatic test_tick_hold();
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      if (k < 13)      exp_q.push_back(mk(4'b0001, 3'd0, 1'b0));
      else if (k < 15) exp_q.push_back(mk(4'b0000, 3'd0, 1'b1));
      else             exp_q.push_back(mk(4'b0000, 3'd0, 1'b0));
      if (k == 0)       drive(4'b0001, 4'b0000, 1'b1);
      else if (k <= 10) drive(4'b0000, 4'b0000, 1'b0);
      else              drive(4'b0000, 4'b0000, 1'b1);
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL tick_hold cyc%0d: got %b want %b", k, obs, e);
      else n_pass++;
    end
  endtask

  // Reset mid-run drops grant without a clock; next request is served with no REST.
  task automatic test_reset_run();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(4'b0100, 3'd2, 1'b0));
      drive(4'b0100, 4'b0000, 1'b1);
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL reset_run pre cyc%0d: got %b want %b", k, obs, e);
      else n_pass++;
    end
    #1 reset = 1'b1;
    #1;
    exp_q.push_back(mk(4'b0000, 3'd0, 1'b0));
    e = exp_q.pop_front();
    n_total++;
    if (obs !== e) $display("FAIL reset_run async: got %b want %b", obs, e);
    else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 3)      exp_q.push_back(mk(4'b0100, 3'd2, 1'b0));
      else if (k < 5) exp_q.push_back(mk(4'b0000, 3'd0, 1'b1));
      else            exp_q.push_back(mk(4'b0000, 3'd0, 1'b0));
      if (k == 0) drive(4'b0100, 4'b0000, 1'b1);
      else        drive(4'b0000, 4'b0000, 1'b1);
      e = exp_q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL reset_run post cyc%0d: got %b want %b", k, obs, e);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    tick    = 1'b0;
    req     = 4'b0000;
    urgent  = 4'b0000;
    test_reset();
    test_basic();
    test_urgent_select();
    test_rotation();
    test_urgent_run();
    test_tick_hold();
    test_reset_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
